// File: rtl/adder64_seq_ctrl_pkg.sv
// Shared definitions for the sequential 64-bit slice adder: default widths
// and the controller state encodings.
package adder64_seq_ctrl_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int SLICE_DEF = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // A new operation may be accepted in any state other than RUN.
  function automatic logic can_accept(input state_t st);
    return (st != ST_RUN);
  endfunction

endpackage

// File: rtl/adder64_seq_ctrl_add_slice.sv
// Purely combinational SLICE-bit ripple-carry adder. The controller reuses
// this single slice for every SLICE-bit chunk of the full-width operands.
module add_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in,
  output logic [SLICE-1:0] sum,
  output logic             c_out
);

  logic [SLICE:0] carry;

  // Explicit bit-by-bit ripple so the slice maps onto a plain carry chain.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c_in;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    c_out = carry[SLICE];
  end

endmodule

// File: rtl/adder64_seq_ctrl.sv
// Multi-cycle add sequencer: latches operands on start, then walks one
// shared SLICE-bit adder from LSB to MSB, carrying between slices through a
// register, and pulses done with the full-width sum and carry-out.
module adder64_seq_ctrl
  import adder64_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

  // A slice width that does not tile the operand would silently drop bits.
  if ((WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("adder64_seq_ctrl: SLICE must divide WIDTH exactly");
  end

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              c_out_q, c_out_d;

  logic [SLICE-1:0]  slice_a;
  logic [SLICE-1:0]  slice_b;
  logic [SLICE-1:0]  slice_sum;
  logic              slice_cout;

  // Select the operand chunk addressed by the current slice index.
  always_comb begin
    slice_a = a_q[idx_q*SLICE +: SLICE];
    slice_b = b_q[idx_q*SLICE +: SLICE];
  end

  add_slice #(
    .SLICE (SLICE)
  ) u_add_slice (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  // Next-state logic: accept in IDLE/DONE, step one slice per cycle in RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && can_accept(state_q)) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[idx_q*SLICE +: SLICE] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == IDX_LAST) begin
          c_out_d = slice_cout;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  // Status outputs decode straight from the registered state.
  always_comb begin
    busy  = (state_q == ST_RUN);
    done  = (state_q == ST_DONE);
    sum   = sum_q;
    c_out = c_out_q;
  end

endmodule

// File: tb/tb_adder64_seq_ctrl.sv
// Scoreboard bench for adder64_seq_ctrl: stimulus pushes expected results,
// a monitor pops and compares them whenever done is seen.
module tb_adder64_seq_ctrl;

  localparam int WIDTH = 64;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             c_out;
  } result_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  result_t sb_q[$];
  int      checks;
  int      errors;
  int      done_count;

  adder64_seq_ctrl #(
    .WIDTH (64),
    .SLICE (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [64:0] actual,
                             input logic [64:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every done cycle consumes one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_count++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done with sum %h, expected no done", sum);
      end else begin
        result_t exp_r;
        exp_r = sb_q.pop_front();
        checkOutput("result", {c_out, sum}, {exp_r.c_out, exp_r.sum});
      end
    end
  end

  // Drive one accepted start (caller ensures DUT is not busy); returns on
  // the first negedge after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] op_a,
                               input logic [WIDTH-1:0] op_b,
                               input logic op_c,
                               input logic [WIDTH-1:0] exp_sum,
                               input logic exp_cout);
    result_t r;
    r.sum   = exp_sum;
    r.c_out = exp_cout;
    sb_q.push_back(r);
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    c_in  = op_c;
    @(negedge clk);
    start = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
  endtask

  // Count cycles from the first negedge after acceptance until done.
  task automatic waitDone(output int lat, output int busy_cycles);
    lat = 1;
    busy_cycles = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runOp(input string name, input logic [WIDTH-1:0] op_a,
                       input logic [WIDTH-1:0] op_b, input logic op_c,
                       input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    int lat;
    int bc;
    applyStimulus(op_a, op_b, op_c, exp_sum, exp_cout);
    waitDone(lat, bc);
    checkOutput({name, "_latency"}, 65'(lat), 65'd5);
    checkOutput({name, "_busy_cycles"}, 65'(bc), 65'd4);
  endtask

  initial begin
    int lat;
    int bc;
    int dc;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic [64:0]      gold;

    checks     = 0;
    errors     = 0;
    done_count = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_busy",  65'(busy), 65'd0);
    checkOutput("reset_done",  65'(done), 65'd0);
    checkOutput("reset_result", {c_out, sum}, 65'd0);

    $display("[TB] directed vectors");
    runOp("small", 64'h1, 64'h2, 1'b0, 64'h3, 1'b0);
    @(negedge clk);
    runOp("full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1);
    @(negedge clk);
    runOp("slice_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
          64'h0000_0000_0001_0000, 1'b0);
    @(negedge clk);
    runOp("msb_carry", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
          64'h0, 1'b1);
    @(negedge clk);

    $display("[TB] start while busy");
    dc = done_count;
    applyStimulus(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0,
                  64'h3333_3333_3333_3333, 1'b0);
    start = 1'b1;
    a     = 64'hFFFF_FFFF_FFFF_FFFF;
    b     = 64'hFFFF_FFFF_FFFF_FFFF;
    c_in  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat, bc);
    checkOutput("busy_ignore_latency", 65'(lat), 65'd4);
    repeat (6) @(negedge clk);
    checkOutput("busy_ignore_done_count", 65'(done_count - dc), 65'd1);
    checkOutput("busy_ignore_hold", {c_out, sum}, {1'b0, 64'h3333_3333_3333_3333});
    checkOutput("idle_busy", 65'(busy), 65'd0);

    $display("[TB] back-to-back");
    applyStimulus(64'h5, 64'h7, 1'b0, 64'hC, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    a     = 64'h1234_5678_9ABC_DEF0;
    b     = 64'h0FED_CBA9_8765_4321;
    c_in  = 1'b0;
    sb_q.push_back('{sum: 64'h2222_2222_2222_2211, c_out: 1'b0});
    @(negedge clk);
    checkOutput("b2b_first_done", 65'(done), 65'd1);
    @(negedge clk);
    start = 1'b0;
    a     = '0;
    b     = '0;
    checkOutput("b2b_second_busy", 65'(busy), 65'd1);
    waitDone(lat, bc);
    checkOutput("b2b_second_latency", 65'(lat), 65'd5);
    @(negedge clk);

    $display("[TB] reset mid-operation");
    runOp("pre_reset", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    @(negedge clk);
    dc = done_count;
    applyStimulus(64'h1, 64'h1, 1'b0, 64'h2, 1'b0);
    void'(sb_q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", 65'(busy), 65'd0);
    checkOutput("midrst_done", 65'(done), 65'd0);
    checkOutput("midrst_result", {c_out, sum}, 65'd0);
    repeat (8) @(negedge clk);
    checkOutput("midrst_no_done", 65'(done_count - dc), 65'd0);

    $display("[TB] random operations");
    for (int i = 0; i < 1000; i++) begin
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom};
      rc   = 1'($urandom_range(0, 1));
      gold = {1'b0, ra} + {1'b0, rb} + {64'h0, rc};
      applyStimulus(ra, rb, rc, gold[63:0], gold[64]);
      waitDone(lat, bc);
      if (lat != 5) checkOutput("rand_latency", 65'(lat), 65'd5);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 65'(sb_q.size()), 65'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
